// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch unit with an in-order fetch queue
// Owns the fetch PC, issues credit-limited requests and discards responses of flushed streams.
module inst_fetch_unit #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 64'h8000_0000,
  parameter int                    DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_inst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [INST_WIDTH-1:0] out_inst
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_d   [DEPTH];
  logic [INST_WIDTH-1:0] inst_q [DEPTH];
  logic [INST_WIDTH-1:0] inst_d [DEPTH];
  logic [DEPTH-1:0]      filled_q, filled_d;
  logic [PW-1:0]         alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]         fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]         head_ptr_q, head_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]         filled_cnt;
  logic [CW-1:0]         unfilled;
  logic                  credit;
  logic                  req_fire;
  logic                  pop;

  // Only allocated entries can be filled, so allocated-minus-filled is the in-flight count.
  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      filled_cnt = filled_cnt + CW'(filled_q[i]);
    end
  end

  assign unfilled       = count_q - filled_cnt;
  assign credit         = ({1'b0, count_q} + {1'b0, drop_cnt_q}) < (CW+1)'(DEPTH);
  assign imem_req_valid = credit && !redirect_valid && !rst;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign out_valid      = filled_q[head_ptr_q] && (count_q != '0) && !redirect_valid;
  assign out_pc         = pc_q[head_ptr_q];
  assign out_inst       = inst_q[head_ptr_q];
  assign pop            = out_valid && out_ready;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    filled_d    = filled_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    count_d     = count_q;
    drop_cnt_d  = drop_cnt_q;
    if (redirect_valid) begin
      // A response landing in the redirect cycle is stale and consumes one drop credit now.
      fetch_pc_d  = redirect_pc;
      filled_d    = '0;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      count_d     = '0;
      drop_cnt_d  = drop_cnt_q + unfilled - CW'(imem_resp_valid);
    end else begin
      if (req_fire) begin
        pc_d[alloc_ptr_q]     = fetch_pc_q;
        filled_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d           = alloc_ptr_q + 1'b1;
        fetch_pc_d            = fetch_pc_q + ADDR_WIDTH'(4);
      end
      if (imem_resp_valid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - 1'b1;
        end else begin
          inst_d[fill_ptr_q]   = imem_resp_inst;
          filled_d[fill_ptr_q] = 1'b1;
          fill_ptr_d           = fill_ptr_q + 1'b1;
        end
      end
      if (pop) begin
        filled_d[head_ptr_q] = 1'b0;
        head_ptr_d           = head_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(req_fire) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
      filled_q    <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      filled_q    <= filled_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      count_q     <= count_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed bench for inst_fetch_unit with an in-order memory model
module tb_inst_fetch_unit;
  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_inst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;

  int errors    = 0;
  int checks    = 0;
  int lat       = 1;
  int cyc       = 0;
  int n_req     = 0;
  int flush_cnt = 0;
  int mem_seen  = 0;
  int base;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  mreq_t m;

  inst_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_inst (imem_resp_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: responds lat cycles after acceptance, in order, with inst = addr[31:0] ^ 0x13.
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_inst  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        m               = mq.pop_front();
        imem_resp_valid = 1'b1;
        imem_resp_inst  = m.addr[31:0] ^ 32'h13;
      end else begin
        imem_resp_valid = 1'b0;
      end
      #2;
      if (flush_cnt != mem_seen) begin
        mem_seen = flush_cnt;
        mq.delete();
        imem_resp_valid = 1'b0;
      end
      #2;
      if (imem_req_valid && imem_req_ready) begin
        n_req++;
        m.addr = imem_req_addr;
        m.due  = cyc + lat;
        mq.push_back(m);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    step();
    rst            = 1'b1;
    flush_cnt++;
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    imem_req_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    #2;
    check1("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_req_addr", imem_req_addr, 64'h8000_0000);
    check1("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pc", out_pc, 64'h0);
    check("rst_out_inst", 64'(out_inst), 64'h0);

    // Straight-line fetch, 1-cycle memory
    step(); rst = 1'b0; #1;
    check1("s1_c0_req_valid", imem_req_valid, 1'b1);
    check("s1_c0_req_addr", imem_req_addr, 64'h8000_0000);
    check1("s1_c0_out_valid", out_valid, 1'b0);
    step(); #1;
    check1("s1_c1_out_valid", out_valid, 1'b0);
    check("s1_c1_req_addr", imem_req_addr, 64'h8000_0004);
    step(); #1;
    check1("s1_c2_out_valid", out_valid, 1'b1);
    check("s1_c2_out_pc", out_pc, 64'h8000_0000);
    check("s1_c2_out_inst", 64'(out_inst), 64'h8000_0013);
    step(); #1;
    check1("s1_c3_out_valid", out_valid, 1'b1);
    check("s1_c3_out_pc", out_pc, 64'h8000_0004);
    check("s1_c3_out_inst", 64'(out_inst), 64'h8000_0017);
    step(); #1;
    check("s1_c4_out_pc", out_pc, 64'h8000_0008);
    check("s1_c4_out_inst", 64'(out_inst), 64'h8000_001B);

    // Backpressure: queue fills to DEPTH then stalls
    reset_dut(); out_ready = 1'b0; lat = 1; base = n_req; #1;
    step(); #1;
    step(); #1;
    step(); #1;
    check1("s2_c3_req_valid", imem_req_valid, 1'b1);
    check("s2_c3_req_addr", imem_req_addr, 64'h8000_000C);
    step(); #1;
    check1("s2_c4_req_valid", imem_req_valid, 1'b0);
    step(); #1;
    check1("s2_c5_req_valid", imem_req_valid, 1'b0);
    check1("s2_c5_out_valid", out_valid, 1'b1);
    check("s2_c5_out_pc", out_pc, 64'h8000_0000);
    step(); out_ready = 1'b1; #1;
    check("s2_c6_req_count", 64'(n_req - base), 64'd4);
    check1("s2_c6_req_valid", imem_req_valid, 1'b0);
    check("s2_c6_pop_pc", out_pc, 64'h8000_0000);
    check("s2_c6_pop_inst", 64'(out_inst), 64'h8000_0013);
    step(); out_ready = 1'b0; #1;
    check1("s2_c7_req_valid", imem_req_valid, 1'b1);
    check("s2_c7_req_addr", imem_req_addr, 64'h8000_0010);
    check("s2_c7_out_pc", out_pc, 64'h8000_0004);
    step(); #1;
    check1("s2_c8_req_valid", imem_req_valid, 1'b0);
    check("s2_c8_req_count", 64'(n_req - base), 64'd5);

    // Redirect with two responses in flight, 3-cycle memory
    reset_dut(); lat = 3; #1;
    step(); #1;
    step(); imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0100; #1;
    check1("s3_c2_out_valid", out_valid, 1'b0);
    check1("s3_c2_req_valid", imem_req_valid, 1'b0);
    step(); redirect_valid = 1'b0; imem_req_ready = 1'b1; #1;
    check("s3_c3_drop_cnt", 64'(dut.drop_cnt_q), 64'd2);
    check1("s3_c3_req_valid", imem_req_valid, 1'b1);
    check("s3_c3_req_addr", imem_req_addr, 64'h8000_0100);
    check1("s3_c3_out_valid", out_valid, 1'b0);
    step(); #1;
    check1("s3_c4_out_valid", out_valid, 1'b0);
    step(); #1;
    check("s3_c5_drop_cnt", 64'(dut.drop_cnt_q), 64'd0);
    check1("s3_c5_out_valid", out_valid, 1'b0);
    step(); #1;
    check1("s3_c6_out_valid", out_valid, 1'b0);
    step(); #1;
    check1("s3_c7_out_valid", out_valid, 1'b1);
    check("s3_c7_out_pc", out_pc, 64'h8000_0100);
    check("s3_c7_out_inst", 64'(out_inst), 64'h8000_0113);
    step(); #1;
    check("s3_c8_out_pc", out_pc, 64'h8000_0104);
    check("s3_c8_out_inst", 64'(out_inst), 64'h8000_0117);

    // Redirect in the same cycle as a response, one other request in flight
    reset_dut(); lat = 2; #1;
    step(); #1;
    step(); imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0200; #1;
    check1("s4_c2_out_valid", out_valid, 1'b0);
    step(); redirect_valid = 1'b0; imem_req_ready = 1'b1; #1;
    check("s4_c3_drop_cnt", 64'(dut.drop_cnt_q), 64'd1);
    check("s4_c3_req_addr", imem_req_addr, 64'h8000_0200);
    check1("s4_c3_out_valid", out_valid, 1'b0);
    step(); #1;
    check("s4_c4_drop_cnt", 64'(dut.drop_cnt_q), 64'd0);
    check1("s4_c4_out_valid", out_valid, 1'b0);
    step(); #1;
    check1("s4_c5_out_valid", out_valid, 1'b0);
    step(); #1;
    check1("s4_c6_out_valid", out_valid, 1'b1);
    check("s4_c6_out_pc", out_pc, 64'h8000_0200);
    check("s4_c6_out_inst", 64'(out_inst), 64'h8000_0213);

    // Redirect while the head is filled and decode is ready
    reset_dut(); lat = 1; #1;
    step(); #1;
    step();
    check1("s5_c2_out_valid_pre", out_valid, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0300; #1;
    check1("s5_c2_out_valid", out_valid, 1'b0);
    check1("s5_c2_req_valid", imem_req_valid, 1'b0);
    step(); redirect_valid = 1'b0; #1;
    check("s5_c3_req_addr", imem_req_addr, 64'h8000_0300);
    check1("s5_c3_req_valid", imem_req_valid, 1'b1);
    check("s5_c3_drop_cnt", 64'(dut.drop_cnt_q), 64'd0);
    check1("s5_c3_out_valid", out_valid, 1'b0);
    step(); #1;
    check1("s5_c4_out_valid", out_valid, 1'b0);
    step(); #1;
    check1("s5_c5_out_valid", out_valid, 1'b1);
    check("s5_c5_out_pc", out_pc, 64'h8000_0300);
    check("s5_c5_out_inst", 64'(out_inst), 64'h8000_0313);

    // Asynchronous reset pulse between clock edges mid-stream
    step();
    check1("s6_pre_out_valid", out_valid, 1'b1);
    check("s6_pre_out_pc", out_pc, 64'h8000_0304);
    rst = 1'b1; flush_cnt++; #1;
    check1("s6_rst_out_valid", out_valid, 1'b0);
    check("s6_rst_req_addr", imem_req_addr, 64'h8000_0000);
    check1("s6_rst_req_valid", imem_req_valid, 1'b0);
    check("s6_rst_out_pc", out_pc, 64'h0);
    rst = 1'b0; #1;
    check1("s6_rel_req_valid", imem_req_valid, 1'b1);
    check("s6_rel_req_addr", imem_req_addr, 64'h8000_0000);
    step(); #1;
    check1("s6_c1_out_valid", out_valid, 1'b0);
    check("s6_c1_req_addr", imem_req_addr, 64'h8000_0004);
    step(); #1;
    check1("s6_c2_out_valid", out_valid, 1'b1);
    check("s6_c2_out_pc", out_pc, 64'h8000_0000);
    check("s6_c2_out_inst", 64'(out_inst), 64'h8000_0013);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
